// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: registered one-hot phase lines plus binary state_code and instr_done.
// Latency: each phase lasts one cycle; a memory phase (IF1/FF1/TF1/IT1) is held while MACK=0 only with SEQ_WAIT_EN defined.
// Backpressure: MACK is the only stall input, and without SEQ_WAIT_EN it is ignored (fixed-latency memory).
module phase_sequencer (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [15:0] m_bus,
    input  logic        MACK,
    input  logic        op_SVC,
    input  logic        EIT_gate,
    input  logic        OIT_gate,
    output logic        IF0,
    output logic        IF1,
    output logic        FF0,
    output logic        FF1,
    output logic        FF2,
    output logic        TF0,
    output logic        TF1,
    output logic        EX0,
    output logic        EX1,
    output logic        IT0,
    output logic        IT1,
    output logic        IT2,
    output logic        MUL1,
    output logic        MUL2_1,
    output logic        MUL2_2,
    output logic        MUL3,
    output logic        MUL4,
    output logic [4:0]  state_code,
    output logic        instr_done
);

    typedef enum logic [4:0] {
        S_IF0    = 5'd0,  S_IF1    = 5'd1,  S_FF0  = 5'd2,  S_FF1  = 5'd3,
        S_FF2    = 5'd4,  S_TF0    = 5'd5,  S_TF1  = 5'd6,  S_EX0  = 5'd7,
        S_EX1    = 5'd8,  S_IT0    = 5'd9,  S_IT1  = 5'd10, S_IT2  = 5'd11,
        S_MUL1   = 5'd12, S_MUL2_1 = 5'd13, S_MUL2_2 = 5'd14, S_MUL3 = 5'd15,
        S_MUL4   = 5'd16
    } state_t;

    state_t      state, next_state;
    logic [16:0] phase;
    logic        src_mem, dst_mem, is_mul;
    logic [3:0]  mul_cnt;
    logic        mem_rdy;
    logic        unused_ok;

`ifdef SEQ_WAIT_EN
    assign mem_rdy   = MACK;
    assign unused_ok = ^{src_mem, m_bus[10:6], m_bus[4:0]};
`else
    assign mem_rdy   = 1'b1;
    assign unused_ok = ^{src_mem, m_bus[10:6], m_bus[4:0], MACK};
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_IF0:    next_state = S_IF1;
            // Flags are not latched yet on this edge, so decode straight from the bus.
            S_IF1: if (mem_rdy) begin
                if (m_bus[5])                    next_state = S_FF0;
                else if (m_bus[11])              next_state = S_TF0;
                else if (m_bus[15:12] == 4'hB)   next_state = S_MUL1;
                else                             next_state = S_EX0;
            end
            S_FF0:    next_state = S_FF1;
            S_FF1:    if (mem_rdy) next_state = S_FF2;
            S_FF2:    next_state = dst_mem ? S_TF0 : (is_mul ? S_MUL1 : S_EX0);
            S_TF0:    next_state = S_TF1;
            S_TF1:    if (mem_rdy) next_state = is_mul ? S_MUL1 : S_EX0;
            S_EX0:    next_state = S_EX1;
            S_EX1:    next_state = (EIT_gate | OIT_gate | op_SVC) ? S_IT0 : S_IF0;
            S_IT0:    next_state = S_IT1;
            S_IT1:    if (mem_rdy) next_state = S_IT2;
            S_IT2:    next_state = S_IF0;
            S_MUL1:   next_state = S_MUL2_1;
            S_MUL2_1: next_state = S_MUL2_2;
            S_MUL2_2: next_state = (mul_cnt != 4'd0) ? S_MUL2_1 : S_MUL3;
            S_MUL3:   next_state = S_MUL4;
            S_MUL4:   next_state = S_EX1;
            default:  next_state = S_IF0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state      <= S_IF0;
            phase      <= 17'd1;
            instr_done <= 1'b0;
            src_mem    <= 1'b0;
            dst_mem    <= 1'b0;
            is_mul     <= 1'b0;
            mul_cnt    <= 4'd0;
        end else begin
            state      <= next_state;
            phase      <= 17'd1 << next_state;
            instr_done <= (next_state == S_EX1);
            if (state == S_IF1 && mem_rdy) begin
                src_mem <= m_bus[5];
                dst_mem <= m_bus[11];
                is_mul  <= (m_bus[15:12] == 4'hB);
            end
            // Load 15 and test before decrement: 16 MUL2 pairs in total.
            if (state == S_MUL1)
                mul_cnt <= 4'd15;
            else if (state == S_MUL2_2)
                mul_cnt <= mul_cnt - 4'd1;
        end
    end

    assign state_code = state;
    assign {MUL4, MUL3, MUL2_2, MUL2_1, MUL1, IT2, IT1, IT0,
            EX1, EX0, TF1, TF0, FF2, FF1, FF0, IF1, IF0} = phase;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer; expected phase sequences are written out by hand per scenario.
module tb_phase_sequencer;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic [15:0] m_bus = 16'h0;
    logic        MACK = 1'b1;
    logic        op_SVC = 1'b0;
    logic        EIT_gate = 1'b0;
    logic        OIT_gate = 1'b0;
    logic IF0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1, IT0, IT1, IT2;
    logic MUL1, MUL2_1, MUL2_2, MUL3, MUL4;
    logic [4:0]  state_code;
    logic        instr_done;
    logic [16:0] ph;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    assign ph = {MUL4, MUL3, MUL2_2, MUL2_1, MUL1, IT2, IT1, IT0,
                 EX1, EX0, TF1, TF0, FF2, FF1, FF0, IF1, IF0};

    phase_sequencer dut (
        .CLK(CLK), .CLR(CLR), .m_bus(m_bus), .MACK(MACK), .op_SVC(op_SVC),
        .EIT_gate(EIT_gate), .OIT_gate(OIT_gate),
        .IF0(IF0), .IF1(IF1), .FF0(FF0), .FF1(FF1), .FF2(FF2), .TF0(TF0), .TF1(TF1),
        .EX0(EX0), .EX1(EX1), .IT0(IT0), .IT1(IT1), .IT2(IT2),
        .MUL1(MUL1), .MUL2_1(MUL2_1), .MUL2_2(MUL2_2), .MUL3(MUL3), .MUL4(MUL4),
        .state_code(state_code), .instr_done(instr_done)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        CLR = 1'b1; MACK = 1'b1; m_bus = 16'h0;
        EIT_gate = 1'b0; OIT_gate = 1'b0; op_SVC = 1'b0;
        tick();
        CLR = 1'b0;
    endtask

    task automatic test_reset;
        CLR = 1'b1; MACK = 1'b0; EIT_gate = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (state_code !== 5'd0 || ph !== 17'd1 || instr_done !== 1'b0) begin
                fails++;
                $display("FAIL reset cyc %0d: code=%0d ph=%h done=%b, want code=0 ph=00001 done=0",
                         i, state_code, ph, instr_done);
            end
        end
        CLR = 1'b0; EIT_gate = 1'b0; MACK = 1'b1;
    endtask

    task automatic test_simple;
        logic [4:0] seq[$] = '{5'd0, 5'd1, 5'd7, 5'd8, 5'd0};
        do_reset();
        m_bus = 16'h1000;
        for (int i = 0; i < seq.size(); i++) begin
            tests++;
            if (state_code !== seq[i] || ph !== (17'd1 << seq[i]) || instr_done !== (i == 3)) begin
                fails++;
                $display("FAIL simple cyc %0d: code=%0d ph=%h done=%b, want code=%0d done=%b",
                         i, state_code, ph, instr_done, seq[i], (i == 3));
            end
            tick();
        end
    endtask

`ifdef SEQ_WAIT_EN
    task automatic test_wait;
        logic [4:0] seq_a[$] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd3, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd0};
        logic [4:0] seq_b[$] = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd7, 5'd8, 5'd9, 5'd10, 5'd10, 5'd11, 5'd0};
        do_reset();
        m_bus = 16'h1820;
        for (int i = 0; i < seq_a.size(); i++) begin
            MACK = !(i == 3 || i == 4);
            tests++;
            if (state_code !== seq_a[i] || ph !== (17'd1 << seq_a[i]) || instr_done !== (seq_a[i] == 5'd8)) begin
                fails++;
                $display("FAIL wait_ff1 cyc %0d: code=%0d ph=%h done=%b, want code=%0d",
                         i, state_code, ph, instr_done, seq_a[i]);
            end
            tick();
        end
        do_reset();
        m_bus = 16'h1000;
        for (int i = 0; i < seq_b.size(); i++) begin
            MACK = !(i == 1 || i == 2 || i == 7);
            EIT_gate = (i == 5);
            tests++;
            if (state_code !== seq_b[i] || ph !== (17'd1 << seq_b[i]) || instr_done !== (seq_b[i] == 5'd8)) begin
                fails++;
                $display("FAIL wait_if1_it1 cyc %0d: code=%0d ph=%h done=%b, want code=%0d",
                         i, state_code, ph, instr_done, seq_b[i]);
            end
            tick();
        end
        MACK = 1'b1; EIT_gate = 1'b0;
    endtask
`else
    task automatic test_wait;
        logic [4:0] seq_a[$] = '{5'd0, 5'd1, 5'd7, 5'd8, 5'd0};
        logic [4:0] seq_b[$] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd0};
        do_reset();
        MACK = 1'b0; m_bus = 16'h1000;
        for (int i = 0; i < seq_a.size(); i++) begin
            tests++;
            if (state_code !== seq_a[i] || ph !== (17'd1 << seq_a[i]) || instr_done !== (seq_a[i] == 5'd8)) begin
                fails++;
                $display("FAIL nowait_ex cyc %0d: code=%0d ph=%h done=%b, want code=%0d",
                         i, state_code, ph, instr_done, seq_a[i]);
            end
            tick();
        end
        do_reset();
        MACK = 1'b0; m_bus = 16'h1820;
        for (int i = 0; i < seq_b.size(); i++) begin
            tests++;
            if (state_code !== seq_b[i] || ph !== (17'd1 << seq_b[i]) || instr_done !== (seq_b[i] == 5'd8)) begin
                fails++;
                $display("FAIL nowait_mem cyc %0d: code=%0d ph=%h done=%b, want code=%0d",
                         i, state_code, ph, instr_done, seq_b[i]);
            end
            tick();
        end
        MACK = 1'b1;
    endtask
`endif

    task automatic test_mul;
        logic [4:0] seq[$];
        seq = '{5'd0, 5'd1, 5'd12};
        for (int k = 0; k < 16; k++) begin
            seq.push_back(5'd13);
            seq.push_back(5'd14);
        end
        seq.push_back(5'd15); seq.push_back(5'd16); seq.push_back(5'd8); seq.push_back(5'd0);
        do_reset();
        m_bus = 16'hB000;
        for (int i = 0; i < seq.size(); i++) begin
            tests++;
            if (state_code !== seq[i] || ph !== (17'd1 << seq[i]) || instr_done !== (seq[i] == 5'd8)) begin
                fails++;
                $display("FAIL mul cyc %0d: code=%0d ph=%h done=%b, want code=%0d",
                         i, state_code, ph, instr_done, seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_interrupt;
        logic [4:0] seq_it[$] = '{5'd0, 5'd1, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd0};
        logic [4:0] seq_no[$] = '{5'd0, 5'd1, 5'd7, 5'd8, 5'd0};
        for (int v = 0; v < 3; v++) begin
            do_reset();
            m_bus = 16'h1000;
            for (int i = 0; i < seq_it.size(); i++) begin
                EIT_gate = (v == 0) ? (i == 3) : (v == 1) ? (i >= 3) : 1'b0;
                OIT_gate = (v == 1) && (i >= 3);
                op_SVC   = (v == 2) && (i == 3);
                tests++;
                if (state_code !== seq_it[i] || ph !== (17'd1 << seq_it[i]) || instr_done !== (seq_it[i] == 5'd8)) begin
                    fails++;
                    $display("FAIL irq_v%0d cyc %0d: code=%0d ph=%h done=%b, want code=%0d",
                             v, i, state_code, ph, instr_done, seq_it[i]);
                end
                tick();
            end
        end
        do_reset();
        m_bus = 16'h1000;
        for (int i = 0; i < seq_no.size(); i++) begin
            EIT_gate = (i == 0 || i == 2);
            OIT_gate = 1'b0; op_SVC = 1'b0;
            tests++;
            if (state_code !== seq_no[i] || ph !== (17'd1 << seq_no[i]) || instr_done !== (seq_no[i] == 5'd8)) begin
                fails++;
                $display("FAIL irq_ignored cyc %0d: code=%0d ph=%h done=%b, want code=%0d",
                         i, state_code, ph, instr_done, seq_no[i]);
            end
            tick();
        end
        EIT_gate = 1'b0; OIT_gate = 1'b0; op_SVC = 1'b0;
    endtask

    task automatic test_clear_midflight;
        logic [4:0] seq[$] = '{5'd0, 5'd1, 5'd7, 5'd8};
        do_reset();
        m_bus = 16'hB000;
        // Ninth MUL2_1 visit is where the counter reads 7.
        for (int i = 0; i < 19; i++) tick();
        tests++;
        if (state_code !== 5'd13) begin
            fails++;
            $display("FAIL clr_mul_pos: code=%0d, want 13", state_code);
        end
        CLR = 1'b1; MACK = 1'b0; EIT_gate = 1'b1;
        tick();
        CLR = 1'b0; MACK = 1'b1; EIT_gate = 1'b0; m_bus = 16'h1000;
        tests++;
        if (state_code !== 5'd0 || ph !== 17'd1 || instr_done !== 1'b0) begin
            fails++;
            $display("FAIL clr_mul: code=%0d ph=%h done=%b, want code=0 ph=00001 done=0",
                     state_code, ph, instr_done);
        end
        for (int i = 0; i < seq.size(); i++) begin
            tests++;
            if (state_code !== seq[i] || ph !== (17'd1 << seq[i]) || instr_done !== (i == 3)) begin
                fails++;
                $display("FAIL clr_refetch cyc %0d: code=%0d ph=%h done=%b, want code=%0d",
                         i, state_code, ph, instr_done, seq[i]);
            end
            if (i < 3) tick();
        end
        // Now in EX1: CLR must beat a pending interrupt.
        CLR = 1'b1; EIT_gate = 1'b1;
        tick();
        CLR = 1'b0; EIT_gate = 1'b0;
        tests++;
        if (state_code !== 5'd0 || ph !== 17'd1 || instr_done !== 1'b0) begin
            fails++;
            $display("FAIL clr_vs_irq: code=%0d ph=%h done=%b, want code=0 ph=00001 done=0",
                     state_code, ph, instr_done);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] seq[$] = '{5'd0, 5'd1, 5'd7, 5'd8,
                               5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8,
                               5'd0, 5'd1, 5'd5, 5'd6, 5'd7, 5'd8, 5'd0};
        do_reset();
        for (int i = 0; i < seq.size(); i++) begin
            // Garbage on the bus outside IF1 must not disturb the latched decode.
            m_bus = (i == 1) ? 16'h1000 : (i == 5) ? 16'h0020 : (i == 12) ? 16'h0800 : 16'hFFFF;
            tests++;
            if (state_code !== seq[i] || ph !== (17'd1 << seq[i]) || instr_done !== (seq[i] == 5'd8)) begin
                fails++;
                $display("FAIL b2b cyc %0d: code=%0d ph=%h done=%b, want code=%0d",
                         i, state_code, ph, instr_done, seq[i]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_wait();
        test_mul();
        test_interrupt();
        test_clear_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
